cmp_nic: RTL and testbench
==========================

// Module: cmp_nic
// PURPOSE
//  Per-node network interface: the responder on the processor's NIC bus (nicEn/nicWrEn/addr_nic/din/dout).
//  Holds one input-channel and one output-channel 64-bit packet buffer, with status registers the processor polls.
//  Bridges the buffers to the router port through a valid/ready handshake.
//  Four instances live inside cmp, one between each node's processor and its router.
// PARAMETERS
//  DATA_W  64  packet/data width, bits [0:DATA_W-1], bit 0 = MSB = virtual-channel (VC) bit
//  ADDR_W  2   processor-side register address width
// PORTS
//  CLK          in   1       system clock, all state on posedge
//  RESET        in   1       asynchronous, active-low reset
//  addr_nic     in   [0:1]   register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
//  din_nic      in   [0:63]  write data from processor
//  dout_nic     out  [0:63]  read data to processor (registered)
//  nicEn        in   1       access enable
//  nicWrEn      in   1       1 = write, 0 = read (qualified by nicEn)
//  net_si       in   1       router -> NIC packet valid
//  net_ri       out  1       NIC -> router ready (input buffer empty)
//  net_di       in   [0:63]  router -> NIC packet
//  net_so       out  1       NIC -> router packet valid (1-cycle pulse)
//  net_ro       in   1       router -> NIC ready
//  net_do       out  [0:63]  NIC -> router packet (registered)
//  net_polarity in   1       router VC phase; NIC injects only when pkt[0] == ~net_polarity
// BEHAVIOUR
//  Reset (RESET=0, async): in_full=0, out_full=0, both buffers=0, dout_nic=0, net_so=0, net_do=0; net_ri=1 follows.
//  Processor reads (nicEn=1, nicWrEn=0): dout_nic updated at the next posedge (1-cycle latency), else holds.
//   00 -> in_buf; if in_full, in_full<=0 on the same edge (consume); if empty, stale in_buf, no state change.
//   01 -> {63'b0,in_full}; 11 -> {63'b0,out_full}; 10 -> 64'b0.
//  Processor writes (nicEn=1, nicWrEn=1):
//   10 with out_full=0 -> out_buf<=din_nic, out_full<=1. With out_full=1 -> dropped, no state change.
//   Writes to 00/01/11 are ignored.
//  Input channel: net_ri = ~in_full (combinational from register).
//   net_si=1 & in_full=0 -> in_buf<=net_di, in_full<=1. net_si=1 & in_full=1 -> dropped (protocol violation).
//  Output channel: send condition S = out_full & net_ro & (out_buf[0] == ~net_polarity), sampled pre-edge.
//   S=1 -> net_so<=1, net_do<=out_buf, out_full<=0. S=0 -> net_so<=0, net_do holds.
//   Fastest back-to-back injection: write cycle t, send at t+1 edge, next write accepted at t+2.
//  Simultaneous events, all on one edge:
//   in-buf read and net_si with in_full=1: read consumes; net_ri was 0, so the packet is not taken.
//   out-buf write and S=1: write sees out_full=1 and is dropped; software must poll 11 first.
//   in-status read returns the pre-edge value.
//  Reset mid-transfer: all buffered packets are discarded; net_so drops asynchronously.
// STRUCTURE
//  nic_defs.vh: localparams NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10,
//   NIC_ADDR_OUT_STAT=2'b11, NIC_VC_BIT=0; shared with cmp and the node decoder.
//  Sub-module nic_chan_buf (one-entry buffer + full flag, load/unload ports), instantiated twice.
//  Top-level holds: address decode, dout_nic register, and the send condition / net_so / net_do registers.
// TESTING
//  1 Reset: RESET=0 mid-run -> dout_nic=0, net_so=0, net_ri=1; read 11 after release -> 64'h0.
//  2 Inject: write 10 = 64'h0000_0000_DEAD_BEEF with net_ro=1, net_polarity=1 -> net_so pulses 1 cycle later;
//    net_do=64'h0000_0000_DEAD_BEEF; status 11 reads 0 afterwards.
//  3 VC gating: write 10 = 64'h8000_0000_0000_0001, net_polarity=1 -> no net_so; toggle polarity to 0 -> net_so next edge.
//  4 Full drop: net_ro=0, write 64'hA then 64'hB to 10 -> 11 reads 1; raise net_ro -> net_do=64'hA, single pulse.
//  5 Receive: net_si=1, net_di=64'h1234 -> net_ri=0 next cycle; second net_si 64'h5678 dropped;
//    read 00 -> dout_nic=64'h1234, net_ri=1.
//  6 Same-edge collision: in_full=1, read 00 while net_si=1 -> read returns old packet, new one not captured;
//    offered again next cycle -> accepted.

Source files
------------

// File: rtl/cmp_nic_pkg.sv
// -----------------------------------------------------------------------------
// cmp_nic_pkg
// Shared definitions for the per-node network interface (cmp_nic): the register
// map seen by the processor on the NIC bus and the position of the
// virtual-channel bit inside a packet. The cmp top level and the node decoder
// also use this package.
// -----------------------------------------------------------------------------
package cmp_nic_pkg;

  // Processor-side register map (addr_nic)
  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  // Packets are numbered [0:DATA_W-1]; bit 0 (the MSB) carries the VC.
  localparam int NIC_VC_BIT = 0;

endpackage : cmp_nic_pkg

// File: rtl/cmp_nic_chan_buf.sv
// -----------------------------------------------------------------------------
// cmp_nic_chan_buf
// One-entry packet buffer with a full flag. A load is accepted only while the
// buffer is empty; an unload clears the full flag and leaves the data in place
// so a later read of an empty buffer returns the stale packet.
//
// Ports
//   CLK          in   system clock, posedge
//   RESET        in   asynchronous, active-low reset
//   load_i       in   request to capture load_data_i (ignored when full)
//   load_data_i  in   packet to capture
//   unload_i     in   consume the held packet (clears full)
//   data_o       out  held packet
//   full_o       out  buffer holds an unconsumed packet
// -----------------------------------------------------------------------------
module cmp_nic_chan_buf #(
  parameter int DATA_W = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load_i,
  input  logic [0:DATA_W-1] load_data_i,
  input  logic              unload_i,
  output logic [0:DATA_W-1] data_o,
  output logic              full_o
);

  logic [0:DATA_W-1] data_q, data_d;
  logic              full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i && !full_q) begin
      data_d = load_data_i;
      full_d = 1'b1;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule : cmp_nic_chan_buf

// File: rtl/cmp_nic.sv
// -----------------------------------------------------------------------------
// cmp_nic
// Per-node network interface between a processor (NIC bus) and its router.
// Holds one input-channel and one output-channel packet buffer plus status
// registers the processor polls, and bridges the buffers to the router port.
//
// Ports
//   CLK           in   system clock, all state on posedge
//   RESET         in   asynchronous, active-low reset
//   addr_nic      in   register select: 00 in-buf, 01 in-status,
//                      10 out-buf, 11 out-status
//   din_nic       in   write data from processor
//   dout_nic      out  read data to processor (registered, 1-cycle latency)
//   nicEn         in   access enable
//   nicWrEn       in   1 = write, 0 = read (qualified by nicEn)
//   net_si        in   router -> NIC packet valid
//   net_ri        out  NIC -> router ready (input buffer empty)
//   net_di        in   router -> NIC packet
//   net_so        out  NIC -> router packet valid (1-cycle pulse)
//   net_ro        in   router -> NIC ready
//   net_do        out  NIC -> router packet (registered)
//   net_polarity  in   router VC phase; inject only when pkt[0] == ~net_polarity
// -----------------------------------------------------------------------------
module cmp_nic
  import cmp_nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [0:ADDR_W-1] addr_nic,
  input  logic [0:DATA_W-1] din_nic,
  output logic [0:DATA_W-1] dout_nic,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  logic              rd_en, wr_en;
  logic              in_full, out_full;
  logic [0:DATA_W-1] in_buf, out_buf;
  logic              in_unload, out_load, send;

  logic [0:DATA_W-1] dout_q, dout_d;
  logic              so_q;
  logic [0:DATA_W-1] do_q, do_d;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn &  nicWrEn;

  // Reading the in-buf consumes it only when it actually holds a packet.
  assign in_unload = rd_en && (addr_nic == NIC_ADDR_IN_BUF) && in_full;
  // A write while the out-buf is still full (including the edge on which it
  // is being sent) is dropped; software polls out-status first.
  assign out_load  = wr_en && (addr_nic == NIC_ADDR_OUT_BUF) && !out_full;
  assign send      = out_full && net_ro && (out_buf[NIC_VC_BIT] == ~net_polarity);

  assign net_ri = ~in_full;

  cmp_nic_chan_buf #(.DATA_W(DATA_W)) u_in_buf (
    .CLK         (CLK),
    .RESET       (RESET),
    .load_i      (net_si),
    .load_data_i (net_di),
    .unload_i    (in_unload),
    .data_o      (in_buf),
    .full_o      (in_full)
  );

  cmp_nic_chan_buf #(.DATA_W(DATA_W)) u_out_buf (
    .CLK         (CLK),
    .RESET       (RESET),
    .load_i      (out_load),
    .load_data_i (din_nic),
    .unload_i    (send),
    .data_o      (out_buf),
    .full_o      (out_full)
  );

  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      case (addr_nic)
        NIC_ADDR_IN_BUF:   dout_d = in_buf;
        NIC_ADDR_IN_STAT:  dout_d = {{(DATA_W-1){1'b0}}, in_full};
        NIC_ADDR_OUT_STAT: dout_d = {{(DATA_W-1){1'b0}}, out_full};
        default:           dout_d = '0;
      endcase
    end
  end

  always_comb begin
    do_d = do_q;
    if (send) do_d = out_buf;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dout_q <= '0;
      so_q   <= 1'b0;
      do_q   <= '0;
    end else begin
      dout_q <= dout_d;
      so_q   <= send;
      do_q   <= do_d;
    end
  end

  assign dout_nic = dout_q;
  assign net_so   = so_q;
  assign net_do   = do_q;

endmodule : cmp_nic

// File: tb/tb_cmp_nic.sv
module tb_cmp_nic;

  logic        CLK;
  logic        RESET;
  logic [0:1]  addr_nic;
  logic [0:63] din_nic;
  logic [0:63] dout_nic;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int n_vec = 0;
  int n_err = 0;

  cmp_nic dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .addr_nic     (addr_nic),
    .din_nic      (din_nic),
    .dout_nic     (dout_nic),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [1:0] a);
    addr_nic = a; nicEn = 1'b1; nicWrEn = 1'b0;
    tick();
    nicEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [63:0] d);
    addr_nic = a; din_nic = d; nicEn = 1'b1; nicWrEn = 1'b1;
    tick();
    nicEn = 1'b0; nicWrEn = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; addr_nic = 2'b00; din_nic = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b1;
    #12;
    chk("rst_dout", dout_nic, 64'h0);
    chk("rst_so",   {63'b0, net_so}, 64'h0);
    chk("rst_ri",   {63'b0, net_ri}, 64'h1);
    chk("rst_do",   net_do, 64'h0);
    @(negedge CLK); RESET = 1'b1;
    tick();

    // Inject: VC bit 0 == ~polarity(1)
    net_ro = 1'b1; net_polarity = 1'b1;
    wr(2'b10, 64'h0000_0000_DEAD_BEEF);
    chk("inj_so_wr_edge", {63'b0, net_so}, 64'h0);
    tick();
    chk("inj_so_pulse", {63'b0, net_so}, 64'h1);
    chk("inj_do",       net_do, 64'h0000_0000_DEAD_BEEF);
    tick();
    chk("inj_so_end",   {63'b0, net_so}, 64'h0);
    rd(2'b11);
    chk("inj_stat",     dout_nic, 64'h0);

    // VC gating
    wr(2'b10, 64'h8000_0000_0000_0001);
    tick();
    chk("vc_no_so",   {63'b0, net_so}, 64'h0);
    rd(2'b11);
    chk("vc_stat",    dout_nic, 64'h1);
    chk("vc_no_so2",  {63'b0, net_so}, 64'h0);
    net_polarity = 1'b0;
    tick();
    chk("vc_so",      {63'b0, net_so}, 64'h1);
    chk("vc_do",      net_do, 64'h8000_0000_0000_0001);
    tick();
    chk("vc_so_end",  {63'b0, net_so}, 64'h0);
    net_polarity = 1'b1;

    // Full drop
    net_ro = 1'b0;
    wr(2'b10, 64'hA);
    wr(2'b10, 64'hB);
    rd(2'b11);
    chk("drop_stat",  dout_nic, 64'h1);
    net_ro = 1'b1;
    tick();
    chk("drop_so",    {63'b0, net_so}, 64'h1);
    chk("drop_do",    net_do, 64'hA);
    tick();
    chk("drop_so_end", {63'b0, net_so}, 64'h0);
    chk("drop_do_hold", net_do, 64'hA);
    rd(2'b11);
    chk("drop_stat0", dout_nic, 64'h0);

    // Register 10 reads zero; writes to 00/01 ignored
    rd(2'b10);
    chk("rd_outbuf_zero", dout_nic, 64'h0);
    wr(2'b00, 64'hFFFF);
    wr(2'b01, 64'hFFFF);
    rd(2'b01);
    chk("wr_ign_stat", dout_nic, 64'h0);
    chk("wr_ign_ri",   {63'b0, net_ri}, 64'h1);

    // Receive
    net_si = 1'b1; net_di = 64'h1234;
    tick();
    chk("rx_ri0", {63'b0, net_ri}, 64'h0);
    net_di = 64'h5678;
    tick();
    net_si = 1'b0;
    rd(2'b01);
    chk("rx_stat1", dout_nic, 64'h1);
    rd(2'b00);
    chk("rx_data",  dout_nic, 64'h1234);
    chk("rx_ri1",   {63'b0, net_ri}, 64'h1);
    // Read of an empty in-buf returns the stale packet, no state change
    rd(2'b00);
    chk("rx_stale", dout_nic, 64'h1234);
    chk("rx_stale_ri", {63'b0, net_ri}, 64'h1);
    // dout holds when not accessed
    tick();
    chk("dout_hold", dout_nic, 64'h1234);

    // Same-edge collision
    net_si = 1'b1; net_di = 64'h1111;
    tick();
    net_di = 64'h2222;
    rd(2'b00);
    chk("col_data", dout_nic, 64'h1111);
    chk("col_ri",   {63'b0, net_ri}, 64'h1);
    tick();
    net_si = 1'b0;
    chk("col_ri0",  {63'b0, net_ri}, 64'h0);
    rd(2'b00);
    chk("col_data2", dout_nic, 64'h2222);

    // Reset mid-transfer
    net_ro = 1'b0;
    wr(2'b10, 64'h77);
    net_si = 1'b1; net_di = 64'h99;
    tick();
    net_si = 1'b0;
    rd(2'b11);
    chk("mid_out_full", dout_nic, 64'h1);
    net_ro = 1'b1;
    tick();
    chk("mid_so_pre", {63'b0, net_so}, 64'h1);
    net_ro = 1'b0;
    RESET = 1'b0;
    #1;
    chk("mid_so",   {63'b0, net_so}, 64'h0);
    chk("mid_dout", dout_nic, 64'h0);
    chk("mid_ri",   {63'b0, net_ri}, 64'h1);
    chk("mid_do",   net_do, 64'h0);
    @(negedge CLK); RESET = 1'b1;
    tick();
    rd(2'b11);
    chk("mid_stat_out", dout_nic, 64'h0);
    rd(2'b01);
    chk("mid_stat_in",  dout_nic, 64'h0);
    rd(2'b00);
    chk("mid_inbuf",    dout_nic, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cmp_nic
